// File: rtl/uart_transmitter.sv
// uart_transmitter: 8-bit UART frame serialiser (start, 8 data LSB first, parity, stop)
module uart_transmitter #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200,
  parameter int DIV = CLK_FREQ / BAUD
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       tx_enable,
  input  logic       even_odd,
  input  logic [7:0] tx_data_in,
  output logic       busy,
  output logic       serial_out
);
  localparam int CW = $clog2(DIV);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] idx, idx_nx;
  logic [7:0] shreg, shreg_nx;
  logic par, par_nx, busy_nx, serial_nx, last;
  assign last = cnt == CW'(DIV - 1);
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      par <= 1'b0;
      busy <= 1'b0;
      serial_out <= 1'b1;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      idx <= idx_nx;
      shreg <= shreg_nx;
      par <= par_nx;
      busy <= busy_nx;
      serial_out <= serial_nx;
    end
  end
  // Outputs are computed one cycle ahead so serial_out and busy come straight from flops.
  always_comb begin
    state_nx = state;
    cnt_nx = (state == IDLE || last) ? '0 : cnt + 1'b1;
    idx_nx = idx;
    shreg_nx = shreg;
    par_nx = par;
    busy_nx = busy;
    serial_nx = serial_out;
    case (state)
      IDLE: if (tx_enable) begin
        state_nx = START;
        shreg_nx = tx_data_in;
        par_nx = even_odd;
        idx_nx = '0;
        busy_nx = 1'b1;
        serial_nx = 1'b0;
      end
      START: if (last) begin
        state_nx = DATA;
        serial_nx = shreg[0];
      end
      DATA: if (last) begin
        if (idx == 3'd7) begin
          state_nx = PARITY;
          serial_nx = ^shreg ^ ~par;
        end else begin
          idx_nx = idx + 3'd1;
          serial_nx = shreg[idx_nx];
        end
      end
      PARITY: if (last) begin
        state_nx = STOP;
        serial_nx = 1'b1;
      end
      STOP: if (last) begin
        state_nx = IDLE;
        busy_nx = 1'b0;
        serial_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: frame-level checks of uart_transmitter against a bit-list reference model
module tb_uart_transmitter;
  localparam int DIV = 50_000_000 / 115200;
  localparam int F = 11 * DIV;
  localparam int WIN = 10000;
  logic sys_clk = 1'b0;
  logic rst_n, tx_enable, even_odd, busy, serial_out;
  logic [7:0] tx_data_in;
  int tests = 0;
  int fails = 0;
  logic bz [WIN];
  logic sl [WIN];

  uart_transmitter dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .tx_enable(tx_enable),
    .even_odd(even_odd),
    .tx_data_in(tx_data_in),
    .busy(busy),
    .serial_out(serial_out)
  );

  always #10 sys_clk = ~sys_clk;

  initial begin
    #(20 * 95000);
    $display("FAIL watchdog: simulation did not finish, required completion within 95000 cycles");
    $fatal(1);
  end

  // Line level for bit k of a frame: start, data LSB first, parity making total ones even/odd, stop.
  function automatic logic frame_bit(logic [7:0] d, logic eo, int k);
    int ones;
    ones = $countones(d);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9) return eo ? (ones % 2 == 1) : (ones % 2 == 0);
    return 1'b1;
  endfunction

  task automatic start_frame(input logic [7:0] d, input logic eo, input string name);
    @(negedge sys_clk);
    tx_data_in = d;
    even_odd = eo;
    tx_enable = 1'b1;
    @(posedge sys_clk);
    #1;
    tx_enable = 1'b0;
    tests++;
    if (serial_out !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_start: serial_out=%b busy=%b, required 0/1", name, serial_out, busy);
    end
  endtask

  // Entered 1 time unit after the launching edge; leaves 1 unit after edge N+11*DIV.
  task automatic check_frame(input logic [7:0] d, input logic eo, input string name);
    int busy_bad = 0;
    logic e;
    for (int c = 0; c < F; c++) begin
      if (c % DIV == DIV / 2) begin
        e = frame_bit(d, eo, c / DIV);
        tests++;
        if (serial_out !== e) begin
          fails++;
          $display("FAIL %s_bit%0d: serial_out=%b required %b", name, c / DIV, serial_out, e);
        end
      end
      if (busy !== 1'b1) busy_bad++;
      @(posedge sys_clk);
      #1;
    end
    tests++;
    if (busy_bad != 0) begin
      fails++;
      $display("FAIL %s_busy_window: busy low in %0d cycles, required 0", name, busy_bad);
    end
    tests++;
    if (busy !== 1'b0 || serial_out !== 1'b1) begin
      fails++;
      $display("FAIL %s_end: busy=%b serial_out=%b, required 0/1", name, busy, serial_out);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tx_enable = 1'b1;
    even_odd = 1'b1;
    tx_data_in = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      @(posedge sys_clk);
      #1;
      tests++;
      if (serial_out !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_cycle%0d: serial_out=%b busy=%b, required 1/0", i, serial_out, busy);
      end
    end
    @(negedge sys_clk);
    tx_enable = 1'b0;
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    tests++;
    if (serial_out !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: serial_out=%b busy=%b, required 1/0", serial_out, busy);
    end
  endtask

  task automatic test_even_parity;
    start_frame(8'hCC, 1'b1, "even_cc");
    check_frame(8'hCC, 1'b1, "even_cc");
  endtask

  task automatic test_odd_parity;
    start_frame(8'hCC, 1'b0, "odd_cc");
    check_frame(8'hCC, 1'b0, "odd_cc");
    start_frame(8'h01, 1'b1, "even_01");
    check_frame(8'h01, 1'b1, "even_01");
  endtask

  task automatic test_back_to_back;
    int starts[$];
    int complete = 0;
    int gap = 0;
    int bad = 0;
    logic ok;
    @(negedge sys_clk);
    tx_data_in = 8'hCC;
    even_odd = 1'b1;
    tx_enable = 1'b1;
    for (int i = 0; i < WIN; i++) begin
      @(posedge sys_clk);
      #1;
      bz[i] = busy;
      sl[i] = serial_out;
    end
    tx_enable = 1'b0;
    for (int i = 0; i < WIN; i++)
      if (bz[i] && (i == 0 || !bz[i-1])) starts.push_back(i);
    foreach (starts[j]) begin
      if (starts[j] + F < WIN) begin
        ok = !bz[starts[j] + F];
        for (int c = 0; c < F; c++) if (!bz[starts[j] + c]) ok = 1'b0;
        if (ok) complete++;
      end
    end
    tests++;
    if (complete != 2) begin
      fails++;
      $display("FAIL b2b_complete_frames: got %0d, required 2", complete);
    end
    tests++;
    if (starts.size() < 2) begin
      fails++;
      $display("FAIL b2b_starts: got %0d frame starts, required at least 2", starts.size());
    end else begin
      tests++;
      if (starts[0] != 0) begin
        fails++;
        $display("FAIL b2b_first_start: cycle %0d, required 0", starts[0]);
      end
      tests++;
      if (starts[1] - starts[0] != F + 1) begin
        fails++;
        $display("FAIL b2b_period: %0d cycles, required %0d", starts[1] - starts[0], F + 1);
      end
      for (int i = starts[0]; i < starts[1]; i++) if (!bz[i]) gap++;
      tests++;
      if (gap != 1) begin
        fails++;
        $display("FAIL b2b_idle_gap: busy low %0d cycles, required 1", gap);
      end
      for (int f = 0; f < 2; f++)
        for (int k = 0; k < 11; k++)
          if (starts[f] + k * DIV + DIV / 2 < WIN &&
              sl[starts[f] + k * DIV + DIV / 2] !== frame_bit(8'hCC, 1'b1, k)) bad++;
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL b2b_content: %0d wrong bits, required 0", bad);
      end
    end
    for (int i = 0; i < F + 10 && busy !== 1'b0; i++) @(posedge sys_clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_mid_frame_change;
    start_frame(8'hCC, 1'b1, "mid");
    fork
      check_frame(8'hCC, 1'b1, "mid");
      begin
        repeat (3 * DIV) @(posedge sys_clk);
        @(negedge sys_clk);
        tx_data_in = 8'h55;
        even_odd = 1'b0;
        tx_enable = 1'b1;
        @(negedge sys_clk);
        tx_enable = 1'b0;
      end
    join
  endtask

  task automatic test_reset_mid_frame;
    start_frame(8'hCC, 1'b1, "rstmid");
    repeat (9 * DIV + DIV / 2) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b0;
    tx_enable = 1'b1;
    @(posedge sys_clk);
    #1;
    tests++;
    if (serial_out !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_abort: serial_out=%b busy=%b, required 1/0", serial_out, busy);
    end
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    tx_enable = 1'b0;
    tests++;
    if (serial_out !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_restart: serial_out=%b busy=%b, required 0/1", serial_out, busy);
    end
    check_frame(8'hCC, 1'b1, "rstmid_fresh");
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic eo;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      eo = 1'($urandom_range(0, 1));
      start_frame(d, eo, $sformatf("rand%0d", i));
      check_frame(d, eo, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tx_enable = 1'b0;
    even_odd = 1'b0;
    tx_data_in = 8'h00;
    test_reset;
    test_even_parity;
    test_odd_parity;
    test_back_to_back;
    test_mid_frame_change;
    test_reset_mid_frame;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmit engine for the system-clock domain. It accepts an 8-bit byte and serialises it onto a single line as one frame: start bit, 8 data bits LSB first, parity bit, stop bit. An internal divider derived from `sys_clk` sets the bit timing. It sits between a byte producer (CPU/FIFO) and the TX pad.

## Interface
- `CLK_FREQ`, default 50_000_000: `sys_clk` frequency in Hz.
- `BAUD`, default 115200: line rate in bits per second.
- `DIV`, default CLK_FREQ/BAUD (434, integer-truncated): `sys_clk` cycles per bit. Must be ≥ 2.

- `sys_clk`, input, 1: sole clock, rising edge. All logic is in this domain.
- `rst_n`, input, 1: reset. Synchronous, active-low, sampled on the `sys_clk` rising edge.
- `tx_enable`, input, 1: level request to send `tx_data_in`. Sampled only in IDLE.
- `even_odd`, input, 1: parity select. 1 = even parity, 0 = odd parity. Latched at frame start.
- `tx_data_in`, input, 8: byte to send. Latched at frame start.
- `busy`, output, 1: high while a frame is in progress, from START through the end of STOP.
- `serial_out`, output, 1: serial line. Idles high. Registered output.

## Operation
- State machine states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `serial_out`=1, `busy`=0.
  - On an edge where `tx_enable`=1, the block does all of the following on that edge:
    - latches `tx_data_in` into the shift register;
    - latches `even_odd`;
    - clears the bit index and baud counter;
    - sets `serial_out`=0 and `busy`=1;
    - moves to START.
- **START**: holds 0 for DIV cycles, then moves to DATA.
- **DATA**
  - Drives shift-register bit `idx`, with idx 0..7, LSB first.
  - Each bit is held for DIV cycles.
  - After bit 7 completes, moves to PARITY.
- **PARITY**
  - Drives XOR of the 8 latched bits when even parity is selected.
  - Drives the inverse of that XOR when odd parity is selected.
  - Holds for DIV cycles, then moves to STOP.
- **STOP**: drives 1 for DIV cycles, then moves to IDLE with `busy`=0.
- **Changes mid-frame**: changes to `tx_data_in`, `even_odd` or `tx_enable` during a frame have no effect on that frame.
- **Back-to-back frames**
  - If `tx_enable` is still high when IDLE is re-entered, the block spends exactly one cycle in IDLE with `serial_out`=1 and `busy`=0.
  - The next frame starts on the following edge.
  - A continuously held `tx_enable` therefore yields repeated frames, separated by a one-cycle idle gap on top of the stop bit.
- **Baud counter**
  - Width ceil(log2(DIV)).
  - Counts 0..DIV-1 within each bit.
  - Wraps to 0 on bit advance.
- **Bit index**: 3 bits.
- **Reset**
  - Any cycle with `rst_n`=0 forces IDLE, `serial_out`=1, `busy`=0, counters cleared and shift register cleared.
  - This applies mid-frame: the frame is aborted and the line returns high on the next edge.
  - No partial frame resumes after reset.

## Timing
- Outputs are registered. No combinational path from inputs to `serial_out` or `busy`.
- Latency: `tx_enable` high at edge N gives `serial_out`=0 and `busy`=1 visible after edge N.
- Bit boundaries fall at edges N + k·DIV, for k=1..11.
  - Start bit: [N, N+DIV).
  - Data bit i: [N+(1+i)·DIV, N+(2+i)·DIV).
  - Parity: [N+9·DIV, N+10·DIV).
  - Stop: [N+10·DIV, N+11·DIV).
- `busy` deasserts after edge N+11·DIV.
- Frame length is 11·DIV cycles. With defaults this is 4774 cycles, 95.48 µs at 50 MHz.
- Minimum frame-to-frame period with `tx_enable` held high is 11·DIV+1 cycles.
- Before the first reset, outputs are undefined. One reset cycle is sufficient.

## Test plan
- **Reset**: hold `rst_n`=0 for 2 cycles with `tx_enable`=1.
  - During reset: `serial_out`=1, `busy`=0.
  - No frame starts during reset.
- **Single frame, even parity**: `tx_data_in`=8'hCC, `even_odd`=1, pulse `tx_enable` for 1 cycle.
  - Line sequence, sampled at mid-bit: 0, 0,0,1,1,0,0,1,1, 0, 1.
  - `busy` high for exactly 11·DIV cycles.
- **Odd parity**: same byte with `even_odd`=0. Parity bit = 1; all other bits are unchanged.
  - Also send 8'h01 with even parity and check parity = 1.
- **Continuous enable**: hold `tx_enable`=1 with 8'hCC for 200 µs at 50 MHz.
  - Exactly two complete frames are sent.
  - `busy` is low for exactly 1 cycle between the frames.
  - Frame starts are 11·DIV+1 cycles apart.
- **Mid-frame changes**: during DATA, change `tx_data_in` to 8'h55 and toggle `even_odd`.
  - The current frame still carries 8'hCC with the originally latched parity.
- **Reset mid-frame**: assert `rst_n`=0 during the PARITY bit.
  - After the next edge: `serial_out`=1, `busy`=0.
  - After `rst_n` is released with `tx_enable`=1, a fresh full frame starts with a start bit.
